// File: rtl/altr_hps_evt_aggr.sv
// Event aggregator: sticky per-source pending bits with ack clear, plus one stretched request line.
// Define ALTR_HPS_EVT_LEVEL_EN for level-sensitive sets; otherwise sources set on rising edges.
module altr_hps_evt_aggr #(
  parameter int NUM_SRC = 4,
  parameter int STRETCH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] evt_in,
  input  logic [NUM_SRC-1:0] evt_mask,
  input  logic               evt_ack,
  input  logic [NUM_SRC-1:0] evt_ack_vec,
  output logic [NUM_SRC-1:0] evt_pend,
  output logic               evt_out
);

  localparam int CNT_W = $clog2(STRETCH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STR  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               out_reg, out_next;
  logic [NUM_SRC-1:0] pend_reg, pend_next;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic               any_pend;

`ifdef ALTR_HPS_EVT_LEVEL_EN
  assign set_vec = evt_in & evt_mask;
`else
  logic [NUM_SRC-1:0] evt_in_d_reg;

  // Cleared on reset so an input already high at release counts as one event.
  always_ff @(posedge clk) begin
    if (rst) evt_in_d_reg <= '0;
    else     evt_in_d_reg <= evt_in;
  end

  assign set_vec = evt_in & ~evt_in_d_reg & evt_mask;
`endif

  assign clr_vec = evt_ack_vec & {NUM_SRC{evt_ack}};

  // A set in the same cycle as its clear wins, so no event is ever lost to an ack race.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
      assign pend_next[gi] = (pend_reg[gi] & ~clr_vec[gi]) | set_vec[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) pend_reg <= '0;
    else     pend_reg <= pend_next;
  end

  assign any_pend = |pend_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      out_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        out_next = 1'b0;
        if (any_pend) begin
          state_next = STR;
          cnt_next   = CNT_LOAD;
          out_next   = 1'b1;
        end
      end
      // Stretch runs to completion regardless of acks; only then does pending matter.
      STR: begin
        out_next = 1'b1;
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (any_pend) begin
          state_next = WAIT;
        end else begin
          state_next = IDLE;
          out_next   = 1'b0;
        end
      end
      WAIT: begin
        out_next = 1'b1;
        if (!any_pend) begin
          state_next = IDLE;
          out_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        out_next   = 1'b0;
      end
    endcase
  end

  assign evt_pend = pend_reg;
  assign evt_out  = out_reg;

endmodule

// File: tb/tb_altr_hps_evt_aggr.sv
// Self-checking bench for altr_hps_evt_aggr: cycle-level model plus directed literal checks.
module tb_altr_hps_evt_aggr;

  localparam int N  = 4;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] evt_in, evt_mask, evt_ack_vec;
  logic         evt_ack;
  logic [N-1:0] evt_pend;
  logic         evt_out;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  altr_hps_evt_aggr #(.NUM_SRC(N), .STRETCH(ST)) dut (
    .clk(clk), .rst(rst), .evt_in(evt_in), .evt_mask(evt_mask),
    .evt_ack(evt_ack), .evt_ack_vec(evt_ack_vec),
    .evt_pend(evt_pend), .evt_out(evt_out)
  );

  always #5 clk = ~clk;

  // Model: pending as a set/clear vector; output rule stated in terms of how long the line has been high.
  logic [N-1:0] m_pend = '0, m_prev = '0, m_set, m_clr;
  logic         m_out = 1'b0, m_nxt;
  int           m_hi = 0;

  always_comb begin
`ifdef ALTR_HPS_EVT_LEVEL_EN
    m_set = evt_in & evt_mask;
`else
    m_set = evt_in & ~m_prev & evt_mask;
`endif
    m_clr = evt_ack ? evt_ack_vec : '0;
    if (m_out) m_nxt = (m_hi < ST) || (m_pend != '0);
    else       m_nxt = (m_pend != '0);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= '0; m_prev <= '0; m_out <= 1'b0; m_hi <= 0;
    end else begin
      m_prev <= evt_in;
      m_pend <= (m_pend & ~m_clr) | m_set;
      m_out  <= m_nxt;
      m_hi   <= m_nxt ? (m_out ? m_hi + 1 : 1) : 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (evt_pend !== m_pend) begin
        failures++;
        $display("FAIL model_pend t=%0t got=%b exp=%b", $time, evt_pend, m_pend);
      end
      checks++;
      if (evt_out !== m_out) begin
        failures++;
        $display("FAIL model_out t=%0t got=%b exp=%b", $time, evt_out, m_out);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [N-1:0] in;
    logic [N-1:0] mask;
    logic         ack;
    logic [N-1:0] vec;
  } vec_t;

  vec_t tbl [0:11];

  initial begin
    tbl[0]  = '{in: 4'b0001, mask: 4'b1111, ack: 1'b0, vec: 4'b0000};
    tbl[1]  = '{in: 4'b0011, mask: 4'b1111, ack: 1'b0, vec: 4'b0000};
    tbl[2]  = '{in: 4'b0010, mask: 4'b1111, ack: 1'b1, vec: 4'b0001};
    tbl[3]  = '{in: 4'b0110, mask: 4'b1011, ack: 1'b0, vec: 4'b0000};
    tbl[4]  = '{in: 4'b1110, mask: 4'b1011, ack: 1'b1, vec: 4'b0010};
    tbl[5]  = '{in: 4'b0000, mask: 4'b1111, ack: 1'b0, vec: 4'b1111};
    tbl[6]  = '{in: 4'b0000, mask: 4'b1111, ack: 1'b1, vec: 4'b1111};
    tbl[7]  = '{in: 4'b0000, mask: 4'b1111, ack: 1'b0, vec: 4'b0000};
    tbl[8]  = '{in: 4'b0100, mask: 4'b1111, ack: 1'b0, vec: 4'b0000};
    tbl[9]  = '{in: 4'b0000, mask: 4'b1111, ack: 1'b1, vec: 4'b0100};
    tbl[10] = '{in: 4'b0001, mask: 4'b1111, ack: 1'b0, vec: 4'b0000};
    tbl[11] = '{in: 4'b0000, mask: 4'b1111, ack: 1'b1, vec: 4'b1111};
  end

  initial begin
    rst = 1'b1; evt_in = '0; evt_mask = '0; evt_ack = 1'b0; evt_ack_vec = '0;
    step(2);
    armed = 1'b1;
    rst = 1'b0; evt_mask = 4'hF;
    step(1); at_neg();
    chk("reset_pend", 32'(evt_pend), 32'h0);
    chk("reset_out", 32'(evt_out), 32'h0);
    $display("reset: pend=%b out=%b", evt_pend, evt_out);

`ifndef ALTR_HPS_EVT_LEVEL_EN
    // Single event, no ack: stretch then hold high.
    evt_in = 4'b0100;
    step(1); at_neg();
    chk("single_pend", 32'(evt_pend), 32'h4);
    chk("single_out_lat", 32'(evt_out), 32'h0);
    step(1); at_neg();
    chk("single_out_rise", 32'(evt_out), 32'h1);
    step(4); at_neg();
    chk("single_out_hold", 32'(evt_out), 32'h1);
    $display("single event: pend=%b out=%b", evt_pend, evt_out);

    evt_ack = 1'b1; evt_ack_vec = 4'b0100;
    step(1);
    evt_ack = 1'b0; evt_ack_vec = '0;
    at_neg();
    chk("ack_pend", 32'(evt_pend), 32'h0);
    chk("ack_out_still", 32'(evt_out), 32'h1);
    step(1); at_neg();
    chk("ack_out_drop", 32'(evt_out), 32'h0);
    step(3); at_neg();
    chk("ack_out_quiet", 32'(evt_out), 32'h0);
    $display("ack clear: pend=%b out=%b", evt_pend, evt_out);

    evt_in = '0;
    step(1);
    evt_in = 4'b0100;
    step(2);
    evt_ack = 1'b1; evt_ack_vec = 4'b0100;
    step(1);
    evt_ack = 1'b0; evt_ack_vec = '0;
    at_neg();
    chk("early_ack_pend", 32'(evt_pend), 32'h0);
    chk("early_ack_out", 32'(evt_out), 32'h1);
    step(2); at_neg();
    chk("early_ack_stretch", 32'(evt_out), 32'h1);
    step(1); at_neg();
    chk("early_ack_drop", 32'(evt_out), 32'h0);
    $display("early ack: pend=%b out=%b", evt_pend, evt_out);

    evt_in = 4'b0001; evt_ack = 1'b1; evt_ack_vec = 4'b0001;
    step(1);
    evt_ack = 1'b0; evt_ack_vec = '0;
    at_neg();
    chk("set_wins_pend", 32'(evt_pend), 32'h1);
    step(6);
    evt_ack = 1'b1; evt_ack_vec = 4'b0001;
    step(1);
    evt_ack = 1'b0; evt_ack_vec = '0;
    step(2); at_neg();
    chk("set_wins_cleared", 32'(evt_out), 32'h0);
    $display("set/clear race: pend=%b out=%b", evt_pend, evt_out);

    evt_mask = 4'b1101; evt_in = 4'b0011;
    step(1); at_neg();
    chk("mask_pend", 32'(evt_pend), 32'h0);
    step(2); at_neg();
    chk("mask_out", 32'(evt_out), 32'h0);
    evt_in = '0;
    step(1);
    evt_in = 4'b1000;
    step(7); at_neg();
    chk("wait_out", 32'(evt_out), 32'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    at_neg();
    chk("rst_mid_out", 32'(evt_out), 32'h0);
    chk("rst_mid_pend", 32'(evt_pend), 32'h0);
    step(1); at_neg();
    chk("rst_release_event", 32'(evt_pend), 32'h8);
    $display("mask + reset: pend=%b out=%b", evt_pend, evt_out);
    evt_in = '0; evt_mask = 4'hF; evt_ack = 1'b1; evt_ack_vec = 4'hF;
    step(1);
    evt_ack = 1'b0; evt_ack_vec = '0;
    step(3);
`else
    evt_in = 4'b1000; evt_ack = 1'b1; evt_ack_vec = 4'b1000;
    step(3);
    for (int i = 0; i < 6; i++) begin
      at_neg();
      chk("level_pend3", 32'(evt_pend[3]), 32'h1);
      chk("level_out", 32'(evt_out), 32'h1);
      step(1);
    end
    evt_in = '0;
    step(1);
    evt_ack = 1'b0; evt_ack_vec = '0;
    at_neg();
    chk("level_rel_pend", 32'(evt_pend), 32'h0);
    chk("level_rel_out1", 32'(evt_out), 32'h1);
    step(1); at_neg();
    chk("level_rel_out2", 32'(evt_out), 32'h0);
    $display("level hold/release: pend=%b out=%b", evt_pend, evt_out);
    step(2);
`endif

    for (int i = 0; i < 12; i++) begin
      evt_in = tbl[i].in; evt_mask = tbl[i].mask;
      evt_ack = tbl[i].ack; evt_ack_vec = tbl[i].vec;
      step(1); at_neg();
      $display("vector %0d: in=%b mask=%b ack=%b vec=%b -> pend=%b out=%b",
               i, tbl[i].in, tbl[i].mask, tbl[i].ack, tbl[i].vec, evt_pend, evt_out);
    end
    evt_in = '0; evt_ack = 1'b0; evt_ack_vec = '0;
    step(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
